// File: rtl/print_pkg.sv
// Shared constants and FSM state type for the print memory write-port arbiter.
package print_pkg;

  localparam int DEPTH = 700;
  localparam int COLS  = 35;

  localparam logic [7:0]  FILL_CHAR  = 8'h20;
  localparam logic [7:0]  NEWLINE    = 8'h0A;
  localparam logic [31:0] BLANK_WORD = {24'h0, FILL_CHAR};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/print_cursor.sv
// Console cursor and column tracking: advance on characters, jump to the next
// row on newline, wrap at the end of the screen, and zero when a clear completes.
module print_cursor #(
  parameter int DEPTH = print_pkg::DEPTH,
  parameter int COLS  = print_pkg::COLS,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          zero,
  input  logic [7:0]    chr,
  output logic [CW-1:0] cursor
);
  import print_pkg::*;

  localparam int          LW      = $clog2(COLS);
  localparam logic [CW:0] COLS_X  = (CW+1)'(COLS);
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  logic [LW-1:0] column;
  logic [CW:0]   nl_sum;

  // Cursor position after a newline: start of the next row, one bit wider to catch overflow
  always_comb begin
    nl_sum = {1'b0, cursor} + COLS_X - (CW+1)'(column);
  end

  // Cursor/column state update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor <= '0;
      column <= '0;
    end else if (zero) begin
      cursor <= '0;
      column <= '0;
    end else if (adv) begin
      if (chr == NEWLINE) begin
        column <= '0;
        cursor <= (nl_sum >= DEPTH_X) ? '0 : nl_sum[CW-1:0];
      end else begin
        column <= (column == LW'(COLS - 1)) ? '0 : column + LW'(1);
        cursor <= (cursor == CW'(DEPTH - 1)) ? '0 : cursor + CW'(1);
      end
    end
  end

endmodule

// File: rtl/print_mem_arbiter.sv
// Print memory write-port owner: arbitrates CPU stores against the console
// character stream (round-robin) and runs a full-screen clear engine.
// Optional build macro PRINT_ARB_BOUNDS_EN drops CPU stores beyond the last
// word and raises a sticky err flag; without it err is tied low.
module print_mem_arbiter #(
  parameter int         DEPTH     = print_pkg::DEPTH,
  parameter int         COLS      = print_pkg::COLS,
  parameter logic [7:0] FILL_CHAR = print_pkg::FILL_CHAR,
  parameter int         CW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [13:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          chr_valid,
  output logic          chr_ready,
  input  logic [7:0]    chr_data,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done,
  output logic [CW-1:0] cursor,
  output logic          mem_we,
  output logic [13:0]   mem_a,
  output logic [31:0]   mem_wd,
  output logic          err
);
  import print_pkg::*;

  localparam logic [31:0] BLANK = {24'h0, FILL_CHAR};

  state_e        state_q, state_d;
  logic [CW-1:0] clr_idx_q, clr_idx_d;
  logic          clr_last;
  logic          last_cpu_q;
  logic          cpu_hs, chr_hs, oob;
  logic          we_d;
  logic [13:0]   a_d;
  logic [31:0]   wd_d;

  assign clr_last = (clr_idx_q == CW'(DEPTH - 1));

`ifdef PRINT_ARB_BOUNDS_EN
  assign oob = (32'(cpu_addr[13:2]) >= DEPTH);
`else
  assign oob = 1'b0;
`endif

  // State register plus every registered output and the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_idx_q  <= '0;
      last_cpu_q <= 1'b0;
      busy       <= 1'b0;
      clr_done   <= 1'b0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy      <= (state_d != IDLE);
      clr_done  <= (state_d == DONE);
      mem_we    <= we_d;
      mem_a     <= a_d;
      mem_wd    <= wd_d;
      if (cpu_hs)      last_cpu_q <= 1'b1;
      else if (chr_hs) last_cpu_q <= 1'b0;
    end
  end

  // Next-state logic: clear sweeps DEPTH words, then one DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_start) state_d = CLEAR;
      CLEAR:   if (clr_last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: readies, handshakes and the next memory-port values
  always_comb begin
    cpu_ready = (state_q == IDLE) && !clr_start && cpu_valid && (!chr_valid || !last_cpu_q);
    chr_ready = (state_q == IDLE) && !clr_start && chr_valid && (!cpu_valid ||  last_cpu_q);
    cpu_hs    = cpu_valid && cpu_ready;
    chr_hs    = chr_valid && chr_ready;
    we_d      = 1'b0;
    a_d       = mem_a;
    wd_d      = mem_wd;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          we_d      = 1'b1;
          a_d       = '0;
          wd_d      = BLANK;
          clr_idx_d = '0;
        end else if (cpu_hs) begin
          we_d = !oob;
          a_d  = cpu_addr;
          wd_d = cpu_wdata;
        end else if (chr_hs && (chr_data != NEWLINE)) begin
          we_d = 1'b1;
          a_d  = 14'({cursor, 2'b00});
          wd_d = {24'h0, chr_data};
        end
      end
      CLEAR: begin
        if (!clr_last) begin
          clr_idx_d = clr_idx_q + CW'(1);
          we_d      = 1'b1;
          a_d       = 14'({clr_idx_q + CW'(1), 2'b00});
          wd_d      = BLANK;
        end
      end
      default: ;
    endcase
  end

`ifdef PRINT_ARB_BOUNDS_EN
  // Sticky out-of-range flag, cleared when a clear starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            err <= 1'b0;
    else if (state_q == IDLE && clr_start) err <= 1'b0;
    else if (cpu_hs && oob)                err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  print_cursor #(
    .DEPTH (DEPTH),
    .COLS  (COLS),
    .CW    (CW)
  ) u_cursor (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv    (chr_hs),
    .zero   ((state_q == CLEAR) && clr_last),
    .chr    (chr_data),
    .cursor (cursor)
  );

endmodule
